// File: rtl/srambank_arb_pkg.sv
// Shared types and defaults for the two-port SRAM bank arbiter.
// Optional feature macro: SRAMBANK_ARB_RR_EN (round-robin arbitration).
package srambank_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 72;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic port_idx_t;

  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/srambank_arb_pick.sv
// Two-requester one-hot grant picker; under contention the pointer port wins.
// Fixed priority is obtained by holding ptr at port 0 (see SRAMBANK_ARB_RR_EN in the top).
module srambank_arb_pick
  import srambank_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/srambank_arb_2p.sv
// Two-port arbiter in front of one synchronous single-port bank, with clear-on-reset.
// Define SRAMBANK_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module srambank_arb_2p
  import srambank_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wd0,
  input  logic [DATA_W-1:0] req_wd1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] bank_address,
  output logic [DATA_W-1:0] bank_wd,
  output logic              bank_banksel,
  output logic              bank_read,
  output logic              bank_write,
  input  logic [DATA_W-1:0] bank_dataout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]        rsp_pend_q, rsp_pend_d;
  logic [1:0]        grant;
  logic [1:0]        pick_req;
  port_idx_t         gnt_idx;
  port_idx_t         ptr;
  logic              init_last;

  assign pick_req  = (state_q == RUN) ? req_valid : 2'b00;
  assign gnt_idx   = grant[1];
  assign init_last = (init_cnt_q == ADDR_W'(DEPTH - 1));

`ifdef SRAMBANK_ARB_RR_EN
  port_idx_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = other_port(gnt_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  srambank_arb_pick u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (grant)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rsp_pend_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rsp_pend_d = grant & ~req_write;
    if (state_q == INIT) begin
      init_cnt_d = init_last ? '0 : init_cnt_q + 1'b1;
      if (init_last) begin
        state_d = RUN;
      end
    end
  end

  // Output logic: bank port is owned by the clear sequence until RUN
  always_comb begin
    bank_banksel = 1'b0;
    bank_read    = 1'b0;
    bank_write   = 1'b0;
    bank_address = '0;
    bank_wd      = '0;
    if (state_q == INIT) begin
      bank_banksel = 1'b1;
      bank_write   = 1'b1;
      bank_address = init_cnt_q;
    end else if (|grant) begin
      bank_banksel = 1'b1;
      bank_address = gnt_idx ? req_addr1 : req_addr0;
      bank_wd      = gnt_idx ? req_wd1 : req_wd0;
      bank_write   = req_write[gnt_idx];
      bank_read    = ~req_write[gnt_idx];
    end
  end

  assign req_ready = grant;
  assign init_done = (state_q == RUN);
  assign rsp_valid = rsp_pend_q;
  assign rsp_data  = bank_dataout;

endmodule

// File: doc/srambank_arb_2p.md
SRAMBANK_ARB_2P -- requirements
Module: srambank_arb_2p

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 8, bank address width.
REQ-002 SHALL have parameter DATA_W, default 72, bank word width.
REQ-003 SHALL have parameter DEPTH, default 256, words cleared by init (2**ADDR_W).

Ports:
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester request valid.
REQ-007 SHALL have port req_ready, output, 2, per-requester grant/accept this cycle.
REQ-008 SHALL have port req_write, input, 2, per-requester 1=write, 0=read.
REQ-009 SHALL have port req_addr0/req_addr1, input, ADDR_W each, request address.
REQ-010 SHALL have port req_wd0/req_wd1, input, DATA_W each, write data.
REQ-011 SHALL have port rsp_valid, output, 2, per-requester read data valid (one cycle, no backpressure).
REQ-012 SHALL have port rsp_data, output, DATA_W, read data for the port flagged in rsp_valid.
REQ-013 SHALL have port init_done, output, 1, high once clear sequence completes.
REQ-014 SHALL have bank-side outputs bank_address (ADDR_W), bank_wd (DATA_W), bank_banksel, bank_read, bank_write (1 each), and input bank_dataout (DATA_W), wired to one synchronous single-port bank.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-016 In INIT SHALL drive bank_banksel=1, bank_write=1, bank_wd=0, bank_address=init counter, increment counter each cycle, enter RUN after writing DEPTH-1; req_ready=0 throughout.
REQ-017 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-018 In RUN SHALL grant at most one requester per cycle; grant is combinational from req_valid and arbitration state; req_ready[p]=1 only for the granted port with req_valid[p]=1.
REQ-019 A granted request SHALL drive bank_banksel=1, bank_address, and bank_write=req_write or bank_read=~req_write in the same cycle; bank_write and bank_read SHALL never both be 1.
REQ-020 With no grant, bank_banksel, bank_read, bank_write SHALL be 0.
REQ-021 A read granted in cycle N SHALL produce rsp_valid[p]=1 in cycle N+1 with rsp_data=bank_dataout; latency exactly 1; back-to-back reads SHALL give back-to-back responses.
REQ-022 Writes SHALL produce no response; a read granted the cycle after a write to the same address SHALL return the new data.
REQ-023 rsp_valid SHALL be one-hot or zero.

Reset
REQ-024 Asserting reset at any time, including mid-INIT or with a read in flight, SHALL set state=INIT, init counter=0, response-pending=0, rsp_valid=0, req_ready=0, priority pointer=port 0.
REQ-025 rsp_data SHALL be bank_dataout (unregistered); only rsp_valid is qualified by reset.

Configuration
REQ-026 With SRAMBANK_ARB_RR_EN defined, arbitration SHALL be round-robin: on a grant the pointer moves to the other port; under contention the pointer port wins.
REQ-027 Without SRAMBANK_ARB_RR_EN, arbitration SHALL be fixed priority, port 0 always winning; no pointer register.

Structure
REQ-028 Shared package srambank_arb_pkg SHALL hold the state enum (INIT, RUN), port-index type, and default ADDR_W/DATA_W constants.
REQ-029 Arbitration SHALL be one sub-module srambank_arb_pick (req vector, pointer -> one-hot grant); FSM, init counter, response tracking in the top.

Verification
REQ-030 Reset release -> 256 consecutive bank writes of 0 at addresses 0..255, req_ready=0, then init_done=1; afterwards reading addr 0x7F returns 0.
REQ-031 Port 0 writes 0xA5 to 0x10, next cycle port 1 reads 0x10 -> rsp_valid=2'b10 one cycle later, rsp_data=0xA5.
REQ-032 Both ports valid reads for 4 cycles with RR_EN -> grants alternate 0,1,0,1; without RR_EN -> port 0 granted all 4, port 1 never ready.
REQ-033 Reset pulsed at init counter 100 -> init restarts at address 0, takes a full 256 cycles.
REQ-034 Read granted, reset asserted next cycle -> rsp_valid stays 0; no response after reset release.
